// File: rtl/tie_cfg_ctrl.sv
// Tie-off configuration sequencer: reset defaults, serial MSB-first shadow load,
// explicit commit to the macro-facing register, and a lock held until reset.
module tie_cfg_ctrl #(
  parameter int unsigned       WIDTH   = 16,
  parameter logic [WIDTH-1:0]  DEFAULT = '1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             sdi,
  input  logic             sdi_valid,
  output logic             sdi_ready,
  input  logic             commit,
  input  logic             lock,
  output logic [WIDTH-1:0] cfg_out,
  output logic             busy,
  output logic             done,
  output logic             locked,
  output logic             err
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_WAIT_COMMIT,
    S_LOCKED
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] cfg_q, cfg_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             ready_q, busy_q, locked_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    cfg_d    = cfg_q;
    err_d    = err_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (lock) begin
          state_d = S_LOCKED;
        end else if (start) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_SHIFT: begin
        // Restart outranks commit and any bit offered in the same cycle
        if (start) begin
          cnt_d = '0;
        end else if (commit) begin
          err_d    = 1'b1;
          shadow_d = cfg_q;
          state_d  = S_IDLE;
        end else if (sdi_valid && ready_q) begin
          shadow_d = {shadow_q[WIDTH-2:0], sdi};
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_d = S_WAIT_COMMIT;
        end
      end
      S_WAIT_COMMIT: begin
        if (start) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
        end else if (commit) begin
          cfg_d   = shadow_q;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_LOCKED: begin
        if (start || commit) err_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered decodes of the next state
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shadow_q <= DEFAULT;
      cfg_q    <= DEFAULT;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      cfg_q    <= cfg_d;
      err_q    <= err_d;
      done_q   <= done_d;
      ready_q  <= (state_d == S_SHIFT);
      busy_q   <= (state_d == S_SHIFT) || (state_d == S_WAIT_COMMIT);
      locked_q <= (state_d == S_LOCKED);
    end
  end

  assign sdi_ready = ready_q;
  assign cfg_out   = cfg_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign locked    = locked_q;
  assign err       = err_q;

endmodule

// File: tb/tb_tie_cfg_ctrl.sv
// Bench for tie_cfg_ctrl: directed scenarios with literal expectations, then
// random traffic, all compared every cycle against a bit-queue reference model.
module tb_tie_cfg_ctrl;
  localparam int          W   = 8;
  localparam logic [7:0]  DEF = 8'hA5;

  logic       CLK = 1'b0, RST = 1'b1;
  logic       start = 1'b0, sdi = 1'b0, sdi_valid = 1'b0, commit = 1'b0, lock = 1'b0;
  logic       sdi_ready, busy, done, locked, err;
  logic [7:0] cfg_out;

  int checks = 0, passes = 0;
  bit chk_en = 1'b0;

  tie_cfg_ctrl #(.WIDTH(W), .DEFAULT(DEF)) dut (
    .CLK(CLK), .RST(RST), .start(start), .sdi(sdi), .sdi_valid(sdi_valid),
    .sdi_ready(sdi_ready), .commit(commit), .lock(lock), .cfg_out(cfg_out),
    .busy(busy), .done(done), .locked(locked), .err(err)
  );

  always #5 CLK = ~CLK;

  // Reference: a load in progress is just the queue of bits received so far
  bit         m_loading = 1'b0, m_locked = 1'b0, m_err = 1'b0, m_done = 1'b0;
  logic [7:0] m_cfg = DEF;
  bit         bits[$];

  function automatic logic [7:0] pack_bits();
    logic [7:0] v = '0;
    foreach (bits[i]) v = {v[6:0], bits[i]};
    return v;
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      m_loading = 1'b0; m_locked = 1'b0; m_err = 1'b0; m_done = 1'b0;
      m_cfg = DEF; bits.delete();
    end else begin
      m_done = 1'b0;
      if (m_locked) begin
        if (start || commit) m_err = 1'b1;
      end else if (!m_loading) begin
        if (lock) m_locked = 1'b1;
        else if (start) begin m_loading = 1'b1; bits.delete(); m_err = 1'b0; end
      end else begin
        if (start) bits.delete();
        else if (bits.size() == W) begin
          if (commit) begin m_cfg = pack_bits(); m_done = 1'b1; m_loading = 1'b0; end
        end else if (commit) begin m_err = 1'b1; m_loading = 1'b0; end
        else if (sdi_valid) bits.push_back(sdi);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("cfg_out",   64'(cfg_out),   64'(m_cfg));
      chk("sdi_ready", 64'(sdi_ready), 64'(m_loading && bits.size() < W));
      chk("busy",      64'(busy),      64'(m_loading));
      chk("done",      64'(done),      64'(m_done));
      chk("locked",    64'(locked),    64'(m_locked));
      chk("err",       64'(err),       64'(m_err));
    end
  end

  task automatic tick(input bit r = 0, input bit s = 0, input bit v = 0,
                      input bit d = 0, input bit c = 0, input bit l = 0);
    RST = r; start = s; sdi_valid = v; sdi = d; commit = c; lock = l;
    @(posedge CLK);
    #1;
  endtask

  task automatic shift_word(input logic [7:0] val, input bit gaps, input int nbits = 8);
    for (int i = 7; i > 7 - nbits; i--) begin
      tick(0, 0, 1, val[i]);
      if (gaps) tick();
    end
  endtask

  task automatic do_reset();
    tick(1); tick(1);
  endtask

  initial begin
    tick(1);
    chk_en = 1'b1;
    tick(1);
    chk("rst cfg_out", 64'(cfg_out), 64'h A5);
    chk("rst flags", 64'({sdi_ready, busy, done, locked, err}), 64'h0);

    // Normal load with gaps
    tick(0, 1);
    chk("start ready/busy", 64'({sdi_ready, busy}), 64'h3);
    shift_word(8'h3C, 1'b1);
    tick(0, 0, 0, 0, 1);
    chk("load cfg", 64'(cfg_out), 64'h3C);
    chk("load done/busy", 64'({done, busy}), 64'h2);
    tick();
    chk("done pulse", 64'(done), 64'h0);

    // Early commit then recovery
    do_reset();
    tick(0, 1);
    shift_word(8'hFF, 1'b0, 5);
    tick(0, 0, 0, 0, 1);
    chk("early err", 64'({err, busy}), 64'h2);
    chk("early cfg", 64'(cfg_out), 64'h A5);
    tick(0, 1);
    chk("err clr", 64'(err), 64'h0);
    shift_word(8'h5A, 1'b0);
    tick(0, 0, 0, 0, 1);
    chk("recover cfg", 64'(cfg_out), 64'h5A);

    // Lock
    do_reset();
    tick(0, 1); shift_word(8'h0F, 1'b0); tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 1);
    chk("locked", 64'(locked), 64'h1);
    tick(0, 1);
    chk("lock err", 64'({locked, err, busy}), 64'h6);
    chk("lock cfg", 64'(cfg_out), 64'h0F);
    tick(1);
    chk("unlock", 64'({cfg_out, locked}), 64'h14A);

    // Reset mid-shift
    tick(0, 1); shift_word(8'hC3, 1'b0, 4);
    tick(1);
    chk("midrst", 64'({cfg_out, sdi_ready, busy}), 64'h294);

    // Restart in WAIT_COMMIT
    do_reset();
    tick(0, 1); shift_word(8'h11, 1'b0);
    chk("wait state", 64'({sdi_ready, busy}), 64'h1);
    tick(0, 1, 0, 0, 1);
    chk("restart", 64'({cfg_out, sdi_ready, done}), 64'h296);
    shift_word(8'hFF, 1'b0);
    tick(0, 0, 0, 0, 1);
    chk("restart cfg", 64'(cfg_out), 64'hFF);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      tick($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 11) == 0, $urandom_range(0, 63) == 0);
    end
    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/tie_cfg_ctrl.md
# tie_cfg_ctrl

Configuration sequencer that owns a bank of WIDTH tie-off control bits for generator macros. After reset the bits take hard defaults, equivalent to a tiehi/tielo pattern. A serial loader with a valid/ready handshake and an explicit commit can then overwrite them, and a lock freezes them until reset. It sits between the chip-level configuration port and the analog/digital macro tie-off pins. The macro sees only `cfg_out`, which changes exactly once per successful commit.

## Interface
- `WIDTH`, 16: number of configuration bits, legal range 2..64.
- `DEFAULT`, {WIDTH{1'b1}}: value loaded into `cfg_out` and the shadow register on reset. All-ones is equivalent to tiehi.
- `CLK` input 1: single clock, rising edge.
- `RST` input 1: synchronous, active-high reset.
- `start` input 1: single-cycle request to begin a load.
- `sdi` input 1: serial data bit, MSB first.
- `sdi_valid` input 1: `sdi` is valid this cycle.
- `sdi_ready` output 1: controller accepts a bit this cycle.
- `commit` input 1: single-cycle request to transfer the shadow register to `cfg_out`.
- `lock` input 1: single-cycle request to freeze the configuration.
- `cfg_out` output WIDTH: registered configuration driving the macro.
- `busy` output 1: high in SHIFT or WAIT_COMMIT.
- `done` output 1: one-cycle pulse after a successful commit.
- `locked` output 1: high in LOCKED.
- `err` output 1: sticky protocol-error flag.

## Operation
- **States:** IDLE, SHIFT, WAIT_COMMIT, LOCKED. All state is registered.
- **Reset:**
  - State goes to IDLE.
  - `cfg_out` and shadow load DEFAULT.
  - Bit counter clears to 0.
  - `sdi_ready`, `busy`, `done`, `locked` and `err` all go to 0.
  - `RST` overrides every other input, including in LOCKED.
- **IDLE:**
  - `lock` goes to LOCKED. `lock` wins over a simultaneous `start`.
  - Otherwise `start` goes to SHIFT, clears the counter and clears `err`.
  - `commit` alone has no effect and is not an error.
- **SHIFT:**
  - A bit is accepted on each cycle with `sdi_valid && sdi_ready`: shadow <= {shadow[WIDTH-2:0], sdi}, and the counter increments.
  - Gaps in `sdi_valid` are allowed and leave the counter unchanged.
  - When the WIDTH-th bit is accepted, go to WAIT_COMMIT.
- **Early commit:** `commit` in SHIFT before WIDTH bits is an error.
  - `err` is set.
  - Shadow reloads from `cfg_out`.
  - State returns to IDLE; `cfg_out` is unchanged.
  - If `commit` coincides with the final accepted bit, it is treated as early, giving an error.
- **WAIT_COMMIT:**
  - `commit` sets cfg_out <= shadow, pulses `done`, and returns to IDLE.
  - `start` discards the shadow contents and re-enters SHIFT with the counter at 0. `start` wins over a simultaneous `commit`.
  - `sdi_valid` is ignored.
- **`start` in SHIFT:** restarts the load with the counter at 0. Shadow is not cleared; its contents are simply overwritten as bits arrive.
- **LOCKED:**
  - `cfg_out` is frozen.
  - `start` or `commit` sets `err` and causes no state change.
  - `lock` is ignored.
  - Exit is only via `RST`.
- **`lock` in SHIFT or WAIT_COMMIT:** ignored and not an error.
- **Counter:** width is $clog2(WIDTH+1). It never exceeds WIDTH.

## Timing
- **`start` sampled at edge t:**
  - State is SHIFT from t+1.
  - `sdi_ready` and `busy` are high from t+1.
- **`sdi_ready`:** a registered decode of state SHIFT. It drops in the cycle after the WIDTH-th acceptance.
- **Load latency:** minimum start-to-`cfg_out` update is WIDTH+2 cycles: 1 cycle start, WIDTH bits, then commit, with the update one edge after commit.
- **`commit` sampled at edge c:**
  - `cfg_out` takes the new value at c+1.
  - `done` is high only in cycle c+1.
  - `busy` is low at c+1.
- **`err`:** set one edge after the offending input. It stays high until an accepted `start` in IDLE or `RST`.
- **`locked`:** high one edge after `lock` is accepted.
- **Mid-operation reset:** `RST` at any edge returns every output to its reset value on that edge; there is no partial commit.
- **Glitch-free output:** `cfg_out` never changes except on a commit edge or a reset edge.

## Test plan
All scenarios use WIDTH=8, DEFAULT=8'hA5.
- **Reset values:** assert `RST` for 2 cycles -> `cfg_out`=0xA5; `sdi_ready`, `busy`, `done`, `locked`, `err` all 0.
- **Normal load with gaps:** `start`, then shift 0x3C MSB-first with `sdi_valid` deasserted every other cycle, then `commit` at edge c -> `cfg_out`=0x3C at c+1; `done` high for exactly 1 cycle; `busy` low at c+1.
- **Early commit:** `start`, 5 bits, `commit` -> `err`=1, state IDLE, `cfg_out` stays 0xA5. Then a full load of 0x5A -> `err` clears on `start`, `cfg_out`=0x5A.
- **Lock:** load 0x0F, then `lock`, then `start` -> `locked`=1, `err`=1, `cfg_out` stays 0x0F. Then `RST` -> `cfg_out`=0xA5, `locked`=0.
- **Reset mid-shift:** `RST` after 4 accepted bits -> `cfg_out`=0xA5, `sdi_ready`=0, `busy`=0 on the same edge.
- **Restart in WAIT_COMMIT:** shift 0x11 so state is WAIT_COMMIT, assert `start` together with `commit`, then shift 0xFF and `commit` -> `cfg_out` never shows 0x11 and ends at 0xFF.
